// File: rtl/cc_lookup_refill_ctrl.sv
// -----------------------------------------------------------------------------
// cc_lookup_refill_ctrl
//
// Sequencer for the cache lookup path. One read request is accepted at a
// time; its address is split into tag [31:14], index [13:6] and offset [5:0].
// A single-cycle lookup pulse is launched to the tag comparator, then the
// controller waits for a hit or miss verdict. On a miss it requests the line
// from memory, writes every returned beat into the data array, then writes
// {valid, tag} into the tag array before signalling completion.
//
// Build option:
//   CC_REFILL_TIMEOUT_EN - when defined, a watchdog aborts a refill that sees
//                          TIMEOUT_CYCLES consecutive cycles without an AR or
//                          R handshake. The request then completes as a
//                          non-hit with err_o set and no tag write.
//
// Parameters:
//   BEATS_PER_LINE - memory beats per 64-byte line (power of 2, 2..16)
//   TIMEOUT_CYCLES - watchdog limit (only with CC_REFILL_TIMEOUT_EN)
//
// Ports:
//   clk, rst_n                    clock, synchronous active-low reset
//   req_valid_i / req_ready_o     upstream request handshake
//   req_addr_i                    request byte address
//   rsp_valid_o / rsp_hit_o       completion pulse and hit/refill indication
//   err_o                         sticky refill error (cleared by reset only)
//   tag_o / index_o / offset_o    lookup fields, held for the whole request
//   hs_pulse_o                    one-cycle lookup launch to the comparator
//   hit_i / miss_i                comparator verdict
//   mem_arvalid_o / mem_arready_i line read request handshake
//   mem_araddr_o                  line-aligned read address {tag, index, 0}
//   mem_rvalid_i / mem_rready_o   read data beat handshake
//   mem_rlast_i                   memory's end-of-burst marker (checked only)
//   data_wren_o                   data array beat write strobe
//   data_windex_o / data_wbeat_o  data array write set and beat position
//   tag_wren_o                    tag array write strobe
//   tag_windex_o / tag_wdata_o    tag array write set and {1'b1, tag}
//
// Every output is a flop; there is no combinational input-to-output path.
// -----------------------------------------------------------------------------
module cc_lookup_refill_ctrl #(
    parameter int BEATS_PER_LINE = 8,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              req_valid_i,
    output logic                              req_ready_o,
    input  logic [31:0]                       req_addr_i,
    output logic                              rsp_valid_o,
    output logic                              rsp_hit_o,
    output logic                              err_o,
    output logic [17:0]                       tag_o,
    output logic [7:0]                        index_o,
    output logic [5:0]                        offset_o,
    output logic                              hs_pulse_o,
    input  logic                              hit_i,
    input  logic                              miss_i,
    output logic                              mem_arvalid_o,
    input  logic                              mem_arready_i,
    output logic [31:0]                       mem_araddr_o,
    input  logic                              mem_rvalid_i,
    output logic                              mem_rready_o,
    input  logic                              mem_rlast_i,
    output logic                              data_wren_o,
    output logic [7:0]                        data_windex_o,
    output logic [$clog2(BEATS_PER_LINE)-1:0] data_wbeat_o,
    output logic                              tag_wren_o,
    output logic [7:0]                        tag_windex_o,
    output logic [18:0]                       tag_wdata_o
);

    localparam int BEAT_W = $clog2(BEATS_PER_LINE);
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS_PER_LINE - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LOOKUP = 3'd1,
        S_WAIT   = 3'd2,
        S_AR     = 3'd3,
        S_REFILL = 3'd4,
        S_TAGWR  = 3'd5,
        S_RESP   = 3'd6
    } state_t;

    state_t            state_r;
    logic [BEAT_W-1:0] beat_cnt_r;
    logic              wd_expire_s;

`ifdef CC_REFILL_TIMEOUT_EN
    // Width holds the value TIMEOUT_CYCLES itself so any limit >= 1 fits.
    localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [WD_W-1:0] wd_cnt_r;
    logic            wd_stall_s;

    // A stall cycle is one spent waiting in AR or REFILL without a handshake.
    assign wd_stall_s = ((state_r == S_AR)     && !mem_arready_i) ||
                        ((state_r == S_REFILL) && !mem_rvalid_i);

    // Fires on the TIMEOUT_CYCLES-th consecutive stall cycle.
    assign wd_expire_s = wd_stall_s && (wd_cnt_r == WD_W'(TIMEOUT_CYCLES - 1));

    // Watchdog: counts consecutive stall cycles, cleared by any handshake or
    // by leaving the memory states.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wd_cnt_r <= '0;
        end else if (wd_stall_s) begin
            wd_cnt_r <= wd_cnt_r + WD_W'(1);
        end else begin
            wd_cnt_r <= '0;
        end
    end
`else
    // Without the watchdog the controller waits on memory indefinitely.
    assign wd_expire_s = 1'b0;
`endif

    // Main sequencer: state register plus every registered output.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            // A reset mid-refill simply abandons the burst; nothing is written.
            state_r       <= S_IDLE;
            beat_cnt_r    <= '0;
            req_ready_o   <= 1'b1;
            rsp_valid_o   <= 1'b0;
            rsp_hit_o     <= 1'b0;
            err_o         <= 1'b0;
            tag_o         <= 18'd0;
            index_o       <= 8'd0;
            offset_o      <= 6'd0;
            hs_pulse_o    <= 1'b0;
            mem_arvalid_o <= 1'b0;
            mem_araddr_o  <= 32'd0;
            mem_rready_o  <= 1'b0;
            data_wren_o   <= 1'b0;
            data_windex_o <= 8'd0;
            data_wbeat_o  <= '0;
            tag_wren_o    <= 1'b0;
            tag_windex_o  <= 8'd0;
            tag_wdata_o   <= 19'd0;
        end else begin
            // Single-cycle strobes drop unless a state below re-asserts them.
            hs_pulse_o  <= 1'b0;
            rsp_valid_o <= 1'b0;
            data_wren_o <= 1'b0;
            tag_wren_o  <= 1'b0;

            case (state_r)
                S_IDLE: begin
                    if (req_valid_i) begin
                        tag_o       <= req_addr_i[31:14];
                        index_o     <= req_addr_i[13:6];
                        offset_o    <= req_addr_i[5:0];
                        req_ready_o <= 1'b0;
                        hs_pulse_o  <= 1'b1;
                        state_r     <= S_LOOKUP;
                    end else begin
                        req_ready_o <= 1'b1;
                    end
                end

                S_LOOKUP: begin
                    // hs_pulse_o was raised on entry and drops via the default.
                    state_r <= S_WAIT;
                end

                S_WAIT: begin
                    // miss_i is checked first so an illegal hit+miss refills.
                    if (miss_i) begin
                        mem_arvalid_o <= 1'b1;
                        mem_araddr_o  <= {tag_o, index_o, 6'd0};
                        state_r       <= S_AR;
                    end else if (hit_i) begin
                        rsp_valid_o <= 1'b1;
                        rsp_hit_o   <= 1'b1;
                        state_r     <= S_RESP;
                    end else begin
                        state_r <= S_WAIT;
                    end
                end

                S_AR: begin
                    if (mem_arready_i) begin
                        mem_arvalid_o <= 1'b0;
                        mem_rready_o  <= 1'b1;
                        beat_cnt_r    <= '0;
                        state_r       <= S_REFILL;
                    end else if (wd_expire_s) begin
                        mem_arvalid_o <= 1'b0;
                        err_o         <= 1'b1;
                        rsp_valid_o   <= 1'b1;
                        rsp_hit_o     <= 1'b0;
                        state_r       <= S_RESP;
                    end else begin
                        state_r <= S_AR;
                    end
                end

                S_REFILL: begin
                    if (mem_rvalid_i) begin
                        data_wren_o   <= 1'b1;
                        data_wbeat_o  <= beat_cnt_r;
                        data_windex_o <= index_o;
                        beat_cnt_r    <= beat_cnt_r + BEAT_W'(1);
                        // The burst length is fixed by the beat count; rlast is
                        // only cross-checked, and any disagreement is flagged.
                        if ((beat_cnt_r == LAST_BEAT) != mem_rlast_i) begin
                            err_o <= 1'b1;
                        end
                        if (beat_cnt_r == LAST_BEAT) begin
                            mem_rready_o <= 1'b0;
                            tag_wren_o   <= 1'b1;
                            tag_windex_o <= index_o;
                            tag_wdata_o  <= {1'b1, tag_o};
                            state_r      <= S_TAGWR;
                        end else begin
                            state_r <= S_REFILL;
                        end
                    end else if (wd_expire_s) begin
                        // Abandon the line: no tag write, so it stays invalid.
                        mem_rready_o <= 1'b0;
                        err_o        <= 1'b1;
                        rsp_valid_o  <= 1'b1;
                        rsp_hit_o    <= 1'b0;
                        state_r      <= S_RESP;
                    end else begin
                        state_r <= S_REFILL;
                    end
                end

                S_TAGWR: begin
                    rsp_valid_o <= 1'b1;
                    rsp_hit_o   <= 1'b0;
                    state_r     <= S_RESP;
                end

                S_RESP: begin
                    rsp_hit_o   <= 1'b0;
                    req_ready_o <= 1'b1;
                    state_r     <= S_IDLE;
                end

                default: begin
                    // Unreachable encoding: drop any handshake and go idle.
                    mem_arvalid_o <= 1'b0;
                    mem_rready_o  <= 1'b0;
                    rsp_hit_o     <= 1'b0;
                    req_ready_o   <= 1'b1;
                    state_r       <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cc_lookup_refill_ctrl.sv
// -----------------------------------------------------------------------------
// tb_cc_lookup_refill_ctrl
//
// Directed bench for cc_lookup_refill_ctrl. A table of request records
// (address, verdict, verdict delay, expected fields) is applied back-to-back,
// followed by hand-written sequences for an early rlast, a reset in the middle
// of a refill, and the stalled-refill behaviour (watchdog abort when
// CC_REFILL_TIMEOUT_EN is defined, indefinite wait otherwise).
// Inputs are driven and outputs sampled on the falling clock edge.
// -----------------------------------------------------------------------------
module tb_cc_lookup_refill_ctrl;

    localparam int BEATS = 8;
    localparam int BW    = 3;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          req_valid;
    logic          req_ready;
    logic [31:0]   req_addr;
    logic          rsp_valid;
    logic          rsp_hit;
    logic          err;
    logic [17:0]   tag;
    logic [7:0]    index;
    logic [5:0]    offset;
    logic          hs_pulse;
    logic          hit;
    logic          miss;
    logic          mem_arvalid;
    logic          mem_arready;
    logic [31:0]   mem_araddr;
    logic          mem_rvalid;
    logic          mem_rready;
    logic          mem_rlast;
    logic          data_wren;
    logic [7:0]    data_windex;
    logic [BW-1:0] data_wbeat;
    logic          tag_wren;
    logic [7:0]    tag_windex;
    logic [18:0]   tag_wdata;

    int total = 0;
    int bad   = 0;
    int tag_wr_cnt = 0;
    int rsp_cnt    = 0;

    cc_lookup_refill_ctrl #(
        .BEATS_PER_LINE(BEATS),
        .TIMEOUT_CYCLES(16)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_valid_i  (req_valid),
        .req_ready_o  (req_ready),
        .req_addr_i   (req_addr),
        .rsp_valid_o  (rsp_valid),
        .rsp_hit_o    (rsp_hit),
        .err_o        (err),
        .tag_o        (tag),
        .index_o      (index),
        .offset_o     (offset),
        .hs_pulse_o   (hs_pulse),
        .hit_i        (hit),
        .miss_i       (miss),
        .mem_arvalid_o(mem_arvalid),
        .mem_arready_i(mem_arready),
        .mem_araddr_o (mem_araddr),
        .mem_rvalid_i (mem_rvalid),
        .mem_rready_o (mem_rready),
        .mem_rlast_i  (mem_rlast),
        .data_wren_o  (data_wren),
        .data_windex_o(data_windex),
        .data_wbeat_o (data_wbeat),
        .tag_wren_o   (tag_wren),
        .tag_windex_o (tag_windex),
        .tag_wdata_o  (tag_wdata)
    );

    always #5 clk = ~clk;

    // Count tag writes and completions seen at each rising edge.
    always @(posedge clk) begin
        if (tag_wren === 1'b1) tag_wr_cnt <= tag_wr_cnt + 1;
        if (rsp_valid === 1'b1) rsp_cnt <= rsp_cnt + 1;
    end

    typedef struct {
        logic [31:0] addr;
        logic        v_hit;
        logic        v_miss;
        int          delay;
        logic [17:0] e_tag;
        logic [7:0]  e_idx;
        logic [5:0]  e_off;
        logic        e_hit;
    } vec_t;

    vec_t vecs[5];

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
        end
    endtask

    // Feed one line of beats with periodic bubbles, starting in the first
    // REFILL cycle; ends in the RESP cycle after checking the tag write.
    task automatic do_refill(input logic [7:0] idx, input logic [17:0] t, input int early_last);
        int   b;
        logic drove;
        b = 0;
        chk("rready_on", mem_rready, 1);
        for (int cyc = 0; cyc < 64 && b < BEATS; cyc++) begin
            drove      = (cyc % 3 != 1);
            mem_rvalid = drove;
            if (drove) begin
                mem_rlast = (early_last >= 0) ? (b == early_last) : (b == BEATS - 1);
                b++;
            end else begin
                mem_rlast = 1'b0;
            end
            tick();
            chk("data_wren", data_wren, drove);
            if (drove) begin
                chk("data_wbeat", data_wbeat, b - 1);
                chk("data_windex", data_windex, idx);
            end
        end
        mem_rvalid = 1'b0;
        mem_rlast  = 1'b0;
        chk("tag_wren", tag_wren, 1);
        chk("tag_windex", tag_windex, idx);
        chk("tag_wdata", tag_wdata, {1'b1, t});
        chk("rready_off", mem_rready, 0);
        tick();
        chk("refill_rsp_valid", rsp_valid, 1);
        chk("refill_rsp_hit", rsp_hit, 0);
        chk("tag_wren_once", tag_wren, 0);
    endtask

    // Run one complete request from the IDLE cycle to the cycle after RESP.
    task automatic run_txn(input vec_t v, input int early_last);
        chk("req_ready", req_ready, 1);
        req_valid = 1'b1;
        req_addr  = v.addr;
        tick();                                   // N+1
        req_valid = 1'b0;
        req_addr  = 32'hDEAD_BEEF;
        chk("hs_pulse", hs_pulse, 1);
        chk("req_ready_busy", req_ready, 0);
        chk("tag", tag, v.e_tag);
        chk("index", index, v.e_idx);
        chk("offset", offset, v.e_off);
        tick();                                   // N+2
        chk("hs_pulse_once", hs_pulse, 0);
        for (int d = 0; d < v.delay; d++) begin
            tick();
            chk("wait_hold", {rsp_valid, mem_arvalid}, 0);
        end
        hit  = v.v_hit;
        miss = v.v_miss;
        tick();                                   // N+3 after the verdict
        hit  = 1'b0;
        miss = 1'b0;
        if (v.e_hit) begin
            chk("hit_rsp_valid", rsp_valid, 1);
            chk("hit_rsp_hit", rsp_hit, 1);
            chk("hit_no_ar", mem_arvalid, 0);
        end else begin
            chk("miss_no_rsp", rsp_valid, 0);
            for (int i = 0; i < 3; i++) begin
                chk("arvalid", mem_arvalid, 1);
                chk("araddr", mem_araddr, {v.e_tag, v.e_idx, 6'd0});
                tick();
            end
            chk("arvalid_at_ready", mem_arvalid, 1);
            mem_arready = 1'b1;
            tick();
            mem_arready = 1'b0;
            chk("arvalid_drop", mem_arvalid, 0);
            do_refill(v.e_idx, v.e_tag, early_last);
        end
        tick();
        chk("ready_back", req_ready, 1);
        chk("rsp_single", rsp_valid, 0);
    endtask

    // Bring a miss request up to the first REFILL cycle with no AR stall.
    task automatic start_miss(input logic [31:0] a);
        req_valid = 1'b1;
        req_addr  = a;
        tick();
        req_valid = 1'b0;
        tick();
        miss = 1'b1;
        tick();
        miss = 1'b0;
        mem_arready = 1'b1;
        tick();
        mem_arready = 1'b0;
    endtask

    initial begin
        int tw0;
        int r0;
        int n;

        vecs[0] = '{32'h1234_5678, 1'b1, 1'b0, 0, 18'h048D1, 8'h59, 6'h38, 1'b1};
        vecs[1] = '{32'h0000_0FC0, 1'b0, 1'b1, 0, 18'h00000, 8'h3F, 6'h00, 1'b0};
        vecs[2] = '{32'hFFFF_FFFF, 1'b1, 1'b1, 0, 18'h3FFFF, 8'hFF, 6'h3F, 1'b0};
        vecs[3] = '{32'hABCD_E03C, 1'b0, 1'b1, 1, 18'h2AF37, 8'h80, 6'h3C, 1'b0};
        vecs[4] = '{32'h0000_4040, 1'b1, 1'b0, 2, 18'h00001, 8'h01, 6'h00, 1'b1};

        rst_n       = 1'b0;
        req_valid   = 1'b0;
        req_addr    = 32'd0;
        hit         = 1'b0;
        miss        = 1'b0;
        mem_arready = 1'b0;
        mem_rvalid  = 1'b0;
        mem_rlast   = 1'b0;
        tick();
        tick();

        // Reset values
        chk("rst_req_ready", req_ready, 1);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_rsp_hit", rsp_hit, 0);
        chk("rst_err", err, 0);
        chk("rst_fields", {tag, index, offset}, 0);
        chk("rst_hs", hs_pulse, 0);
        chk("rst_ar", {mem_arvalid, mem_rready}, 0);
        chk("rst_araddr", mem_araddr, 0);
        chk("rst_data", {data_wren, data_windex, data_wbeat}, 0);
        chk("rst_tagwr", {tag_wren, tag_windex}, 0);
        chk("rst_tag_wdata", tag_wdata, 0);
        rst_n = 1'b1;
        tick();

        // Table of requests, applied back-to-back
        for (int k = 0; k < 5; k++) begin
            run_txn(vecs[k], -1);
        end
        chk("no_err_after_table", err, 0);

        // rlast asserted early on beat 5: error, but all 8 beats and tag write
        tw0 = tag_wr_cnt;
        run_txn('{32'h0001_2340, 1'b0, 1'b1, 0, 18'h00004, 8'h8D, 6'h00, 1'b0}, 5);
        chk("rlast_err", err, 1);
        chk("rlast_tag_written", tag_wr_cnt - tw0, 1);

        // Reset asserted while beat 3 is presented
        start_miss(32'h0000_2A80);
        tw0 = tag_wr_cnt;
        for (int b = 0; b < 4; b++) begin
            mem_rvalid = 1'b1;
            mem_rlast  = 1'b0;
            if (b == 3) rst_n = 1'b0;
            tick();
        end
        mem_rvalid = 1'b0;
        chk("mid_rst_ready", req_ready, 1);
        chk("mid_rst_rready", mem_rready, 0);
        chk("mid_rst_data_wren", data_wren, 0);
        chk("mid_rst_err", err, 0);
        chk("mid_rst_fields", {tag, index, offset}, 0);
        chk("mid_rst_strobes", {tag_wren, rsp_valid, hs_pulse, mem_arvalid}, 0);
        rst_n = 1'b1;
        tick();
        tick();
        tick();
        chk("mid_rst_no_tagwr", tag_wr_cnt - tw0, 0);
        chk("mid_rst_idle", req_ready, 1);

        // Refill with no data beats after the AR handshake
        start_miss(32'h8000_0000);
        tw0 = tag_wr_cnt;
`ifdef CC_REFILL_TIMEOUT_EN
        n = 0;
        while (rsp_valid !== 1'b1 && n < 64) begin
            tick();
            n++;
        end
        chk("timeout_latency", n, 16);
        chk("timeout_rsp_hit", rsp_hit, 0);
        chk("timeout_err", err, 1);
        chk("timeout_rready", mem_rready, 0);
        tick();
        chk("timeout_no_tagwr", tag_wr_cnt - tw0, 0);
        chk("timeout_ready", req_ready, 1);
        r0 = rsp_cnt;
        chk("timeout_rsp_seen", r0 > 0, 1);
`else
        r0 = rsp_cnt;
        n  = 0;
        repeat (40) begin
            tick();
            n++;
        end
        chk("stall_rready", mem_rready, 1);
        chk("stall_no_rsp", rsp_cnt - r0, 0);
        chk("stall_no_err", err, 0);
        do_refill(8'h00, 18'h20000, -1);
        tick();
        chk("stall_ready", req_ready, 1);
        chk("stall_tagwr", tag_wr_cnt - tw0, 1);
        chk("stall_err_clean", err, 0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Absolute bound on run time in case the sequencing above ever wedges.
    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1);
    end

endmodule
